// File: rtl/rx_adc_interface_if.sv
// Settings-bus write port shared by the host (master) and the RX ADC front end (slave).
interface rx_adc_interface_if;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic        serial_strobe;

  modport master (output serial_addr, serial_data, serial_strobe);
  modport slave  (input  serial_addr, serial_data, serial_strobe);
endinterface

// File: rtl/rx_adc_interface.sv
// RX ADC front end: input register, per-ADC DC offset removal (host or closed loop),
// RSSI/overload averaging and settings-driven routing of the four ADCs onto the DDC I/Q inputs.
module rx_adc_interface #(
  parameter int ADDR_RX_MUX   = 38,
  parameter int ADDR_ADC_OFS0 = 50,
  parameter int ADDR_DC_CL_EN = 54
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  rx_adc_interface_if.slave    sbus,
  input  logic [11:0]          rx_a_a,
  input  logic [11:0]          rx_b_a,
  input  logic [11:0]          rx_a_b,
  input  logic [11:0]          rx_b_b,
  output logic [31:0]          rssi_0,
  output logic [31:0]          rssi_1,
  output logic [31:0]          rssi_2,
  output logic [31:0]          rssi_3,
  output logic [15:0]          ddc0_in_i,
  output logic [15:0]          ddc0_in_q,
  output logic [15:0]          ddc1_in_i,
  output logic [15:0]          ddc1_in_q,
  output logic [15:0]          ddc2_in_i,
  output logic [15:0]          ddc2_in_q,
  output logic [15:0]          ddc3_in_i,
  output logic [15:0]          ddc3_in_q,
  output logic [3:0]           rx_numchan
);

  logic [11:0] rx_pin [4];
  logic [20:0] mux_reg;
  logic [3:0]  cl_en;
  logic [11:0] s1     [4];
  logic [15:0] s2     [4];
  logic [31:0] acc    [4];
  logic [25:0] r_acc  [4];
  logic [25:0] o_acc  [4];
  logic [15:0] ddc_i  [4];
  logic [15:0] ddc_q  [4];

  logic [15:0] adc16   [4];
  logic [16:0] diff    [4];
  logic [15:0] sat_out [4];
  logic [11:0] abs_v   [4];
  logic [3:0]  over;
  logic [25:0] r_next  [4];
  logic [25:0] o_next  [4];
  logic [3:0]  ofs_wr;
  logic        mux_wr;
  logic        cl_wr;
  logic        unused_data_bits;

  assign rx_pin[0] = rx_a_a;
  assign rx_pin[1] = rx_b_a;
  assign rx_pin[2] = rx_a_b;
  assign rx_pin[3] = rx_b_b;

  assign mux_wr = sbus.serial_strobe && (sbus.serial_addr == 7'(ADDR_RX_MUX));
  assign cl_wr  = sbus.serial_strobe && (sbus.serial_addr == 7'(ADDR_DC_CL_EN));
  assign unused_data_bits = &{1'b0, sbus.serial_data[31:21]};

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      adc16[n] = {s1[n][11], s1[n], 3'b000};
      // 17-bit difference so an overflow of the 16-bit range is visible in the top two bits
      diff[n]  = {adc16[n][15], adc16[n]} - {acc[n][31], acc[n][31:16]};
      if (diff[n][16] != diff[n][15]) sat_out[n] = diff[n][16] ? 16'h8000 : 16'h7fff;
      else                            sat_out[n] = diff[n][15:0];
      abs_v[n]  = s1[n][11] ? (~s1[n] + 12'd1) : s1[n];
      over[n]   = (s1[n] == 12'h7ff) || (s1[n] == 12'h800);
      r_next[n] = r_acc[n] + {14'd0, abs_v[n]} - {10'd0, r_acc[n][25:10]};
      o_next[n] = o_acc[n] + (over[n] ? 26'd65535 : 26'd0) - {10'd0, o_acc[n][25:10]};
      ofs_wr[n] = sbus.serial_strobe && (sbus.serial_addr == 7'(ADDR_ADC_OFS0 + n));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mux_reg <= '0;
      cl_en   <= '0;
      for (int n = 0; n < 4; n++) begin
        s1[n] <= '0; s2[n] <= '0; acc[n] <= '0;
        r_acc[n] <= '0; o_acc[n] <= '0;
        ddc_i[n] <= '0; ddc_q[n] <= '0;
      end
    end else begin
      if (mux_wr) mux_reg <= sbus.serial_data[20:0];
      if (cl_wr)  cl_en   <= sbus.serial_data[3:0];
      for (int n = 0; n < 4; n++) begin
        // a host offset write overrides the loop integration on the same edge
        if (ofs_wr[n])                  acc[n] <= {sbus.serial_data[15:0], 16'h0000};
        else if (cl_en[n] && enable)    acc[n] <= acc[n] + {{16{s2[n][15]}}, s2[n]};
        if (enable) begin
          s1[n]    <= rx_pin[n];
          s2[n]    <= sat_out[n];
          r_acc[n] <= r_next[n];
          o_acc[n] <= o_next[n];
          ddc_i[n] <= s2[mux_reg[5+4*n +: 2]];
          ddc_q[n] <= mux_reg[4] ? 16'h0000 : s2[mux_reg[7+4*n +: 2]];
        end
      end
    end
  end

  assign rssi_0 = {o_acc[0][25:10], r_acc[0][25:10]};
  assign rssi_1 = {o_acc[1][25:10], r_acc[1][25:10]};
  assign rssi_2 = {o_acc[2][25:10], r_acc[2][25:10]};
  assign rssi_3 = {o_acc[3][25:10], r_acc[3][25:10]};
  assign ddc0_in_i = ddc_i[0];
  assign ddc0_in_q = ddc_q[0];
  assign ddc1_in_i = ddc_i[1];
  assign ddc1_in_q = ddc_q[1];
  assign ddc2_in_i = ddc_i[2];
  assign ddc2_in_q = ddc_q[2];
  assign ddc3_in_i = ddc_i[3];
  assign ddc3_in_q = ddc_q[3];
  assign rx_numchan = mux_reg[3:0];

endmodule

// File: tb/tb_rx_adc_interface.sv
// Bench for rx_adc_interface: directed scenarios plus random traffic, checked each clock
// against an integer reference model through an expected-output queue.
module tb_rx_adc_interface;
  localparam int W = 260;

  logic clock = 1'b0;
  logic reset, enable;
  logic [11:0] rx_a_a, rx_b_a, rx_a_b, rx_b_b;
  logic [31:0] rssi_0, rssi_1, rssi_2, rssi_3;
  logic [15:0] ddc0_in_i, ddc0_in_q, ddc1_in_i, ddc1_in_q;
  logic [15:0] ddc2_in_i, ddc2_in_q, ddc3_in_i, ddc3_in_q;
  logic [3:0]  rx_numchan;

  rx_adc_interface_if sbus ();

  rx_adc_interface dut (
    .clock(clock), .reset(reset), .enable(enable), .sbus(sbus),
    .rx_a_a(rx_a_a), .rx_b_a(rx_b_a), .rx_a_b(rx_a_b), .rx_b_b(rx_b_b),
    .rssi_0(rssi_0), .rssi_1(rssi_1), .rssi_2(rssi_2), .rssi_3(rssi_3),
    .ddc0_in_i(ddc0_in_i), .ddc0_in_q(ddc0_in_q), .ddc1_in_i(ddc1_in_i), .ddc1_in_q(ddc1_in_q),
    .ddc2_in_i(ddc2_in_i), .ddc2_in_q(ddc2_in_q), .ddc3_in_i(ddc3_in_i), .ddc3_in_q(ddc3_in_q),
    .rx_numchan(rx_numchan)
  );

  // clock / reset block
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  // reference model state, plain integers
  int rx_v  [4];
  int m_s1  [4];
  int m_out [4];
  int m_acc [4];
  int m_r   [4];
  int m_o   [4];
  int m_di  [4];
  int m_dq  [4];
  int m_mux, m_cl;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat16(input int x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic int to_signed12(input int raw);
    return (raw >= 2048) ? raw - 4096 : raw;
  endfunction

  function automatic int abs_i(input int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic model_step(input bit rst, input bit en, input bit st, input int addr, input int data);
    int o_out[4], o_s1[4];
    int o_mux, o_cl;
    o_out = m_out; o_s1 = m_s1; o_mux = m_mux; o_cl = m_cl;
    if (rst) begin
      for (int n = 0; n < 4; n++) begin
        m_s1[n] = 0; m_out[n] = 0; m_acc[n] = 0; m_r[n] = 0; m_o[n] = 0; m_di[n] = 0; m_dq[n] = 0;
      end
      m_mux = 0; m_cl = 0;
      return;
    end
    if (st && addr == 38) m_mux = data & 32'h001f_ffff;
    if (st && addr == 54) m_cl  = data & 15;
    for (int n = 0; n < 4; n++) begin
      if (en) begin
        m_out[n] = sat16(o_s1[n] * 8 - (m_acc[n] >>> 16));
        m_s1[n]  = to_signed12(rx_v[n]);
        m_r[n]   = m_r[n] + abs_i(o_s1[n]) - m_r[n] / 1024;
        m_o[n]   = m_o[n] + ((o_s1[n] == 2047 || o_s1[n] == -2048) ? 65535 : 0) - m_o[n] / 1024;
        m_di[n]  = o_out[(o_mux >> (5 + 4*n)) & 3];
        m_dq[n]  = ((o_mux >> 4) & 1) ? 0 : o_out[(o_mux >> (7 + 4*n)) & 3];
      end
      if (st && addr == 50 + n)            m_acc[n] = data << 16;
      else if (en && ((o_cl >> n) & 1))    m_acc[n] = m_acc[n] + o_out[n];
    end
  endtask

  function automatic logic [W-1:0] pack_model();
    logic [W-1:0] e;
    e = '0;
    for (int n = 0; n < 4; n++) begin
      e[259-32*n -: 32] = {16'(m_di[n]), 16'(m_dq[n])};
      e[131-32*n -: 32] = {16'(m_o[n] / 1024), 16'(m_r[n] / 1024)};
    end
    e[3:0] = 4'(m_mux);
    return e;
  endfunction

  // driver: one clock per call, expected post-edge outputs queued before the edge
  task automatic cyc(input bit rst, input bit en, input bit st = 1'b0, input int addr = 0, input int data = 0);
    @(negedge clock);
    reset = rst; enable = en;
    sbus.serial_strobe = st; sbus.serial_addr = 7'(addr); sbus.serial_data = 32'(data);
    rx_a_a = 12'(rx_v[0]); rx_b_a = 12'(rx_v[1]); rx_a_b = 12'(rx_v[2]); rx_b_b = 12'(rx_v[3]);
    model_step(rst, en, st, addr, data);
    exp_q.push_back(pack_model());
    @(posedge clock);
    #2;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) cyc(1'b0, 1'b1);
  endtask

  task automatic set_all(input int v);
    for (int n = 0; n < 4; n++) rx_v[n] = v;
  endtask

  // monitor / scoreboard
  always @(posedge clock) begin
    logic [W-1:0] e, a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {ddc0_in_i, ddc0_in_q, ddc1_in_i, ddc1_in_q, ddc2_in_i, ddc2_in_q, ddc3_in_i, ddc3_in_q,
           rssi_0, rssi_1, rssi_2, rssi_3, rx_numchan};
      check("ddc", 128'(a[259:132]), 128'(e[259:132]));
      check("rssi", 128'(a[131:4]), 128'(e[131:4]));
      check("numchan", 128'(a[3:0]), 128'(e[3:0]));
    end
  end

  initial begin
    logic [255:0] snap;
    int prev, cur, rv;
    bit mono;
    sbus.serial_strobe = 1'b0; sbus.serial_addr = '0; sbus.serial_data = '0;
    reset = 1'b1; enable = 1'b1;
    set_all(12'h123);

    // reset and default routing
    cyc(1'b1, 1'b1); cyc(1'b1, 1'b1);
    check("reset_ddc0_i", 128'(ddc0_in_i), 128'h0);
    check("reset_rssi0", 128'(rssi_0), 128'h0);
    run(3);
    check("default_ddc0_i", 128'(ddc0_in_i), 128'h0918);
    check("default_ddc3_q", 128'(ddc3_in_q), 128'h0918);
    check("default_numchan", 128'(rx_numchan), 128'h0);

    // mux: ddc0 I from ADC0, Q from ADC1, two channels
    rx_v[0] = 12'h100; rx_v[1] = 12'hF00;
    cyc(1'b0, 1'b1, 1'b1, 38, 32'h0000_0082);
    run(3);
    check("mux_ddc0_i", 128'(ddc0_in_i), 128'h0800);
    check("mux_ddc0_q", 128'(ddc0_in_q), 128'hF800);
    check("mux_numchan", 128'(rx_numchan), 128'h2);
    cyc(1'b0, 1'b1, 1'b1, 38, 32'h0000_0092);
    run(1);
    check("realsig_q0", 128'(ddc0_in_q), 128'h0);

    // host offset and saturation
    cyc(1'b0, 1'b1, 1'b1, 38, 0);
    rx_v[0] = 12'h020;
    cyc(1'b0, 1'b1, 1'b1, 50, 32'h0000_0100);
    run(3);
    check("offset_zero", 128'(ddc0_in_i), 128'h0);
    rx_v[0] = 12'h800;
    cyc(1'b0, 1'b1, 1'b1, 50, 32'h0000_7FFF);
    run(3);
    check("offset_sat", 128'(ddc0_in_i), 128'h8000);

    // closed-loop offset removal
    rx_v[0] = 12'h040;
    cyc(1'b0, 1'b1, 1'b1, 50, 0);
    run(3);
    cyc(1'b0, 1'b1, 1'b1, 54, 1);
    prev = 32767; mono = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cyc(1'b0, 1'b1);
      cur = int'($signed(ddc0_in_i));
      if (cur > prev) mono = 1'b0;
      prev = cur;
    end
    check("cl_monotonic", 128'(mono), 128'h1);
    check("cl_decaying", 128'(prev < 512), 128'h1);
    cyc(1'b0, 1'b1, 1'b1, 54, 0);
    cyc(1'b0, 1'b1, 1'b1, 50, 0);

    // RSSI and overload averaging on ADC2
    rx_v[2] = 12'h7FF;
    run(12000);
    check("rssi2_level", 128'(rssi_2[15:0] >= 16'd2026 && rssi_2[15:0] <= 16'd2068), 128'h1);
    check("rssi2_over", 128'(rssi_2[31:16] >= 16'd64880), 128'h1);
    rx_v[2] = 0;
    run(2000);
    check("rssi2_decay", 128'(rssi_2[15:0] < 16'd500), 128'h1);
    check("over2_decay", 128'(rssi_2[31:16] < 16'd16000), 128'h1);

    // enable low freezes everything
    snap = {ddc0_in_i, ddc0_in_q, ddc1_in_i, ddc1_in_q, ddc2_in_i, ddc2_in_q, ddc3_in_i, ddc3_in_q,
            rssi_0, rssi_1, rssi_2, rssi_3};
    for (int i = 0; i < 10; i++) begin
      for (int n = 0; n < 4; n++) rx_v[n] = $urandom_range(0, 4095);
      cyc(1'b0, 1'b0);
    end
    check("freeze_ddc", 128'({ddc0_in_i, ddc0_in_q, ddc1_in_i, ddc1_in_q,
                              ddc2_in_i, ddc2_in_q, ddc3_in_i, ddc3_in_q}), snap[255:128]);
    check("freeze_rssi", 128'({rssi_0, rssi_1, rssi_2, rssi_3}), snap[127:0]);
    set_all(12'h055);
    run(3);
    check("resume_latency", 128'(ddc0_in_i), 128'h02A8);

    // random traffic with occasional writes, enable drops and resets
    for (int i = 0; i < 3000; i++) begin
      for (int n = 0; n < 4; n++) begin
        rv = $urandom_range(0, 15);
        if (rv == 0)      rx_v[n] = 12'h7FF;
        else if (rv == 1) rx_v[n] = 12'h800;
        else              rx_v[n] = $urandom_range(0, 4095);
      end
      rv = $urandom_range(0, 99);
      if (rv == 0)       cyc(1'b1, 1'b1);
      else if (rv < 4)   cyc(1'b0, $urandom_range(0, 1) == 1, 1'b1, 38, $urandom);
      else if (rv < 8)   cyc(1'b0, $urandom_range(0, 1) == 1, 1'b1, $urandom_range(50, 53), $urandom);
      else if (rv < 10)  cyc(1'b0, 1'b1, 1'b1, 54, $urandom);
      else if (rv < 12)  cyc(1'b0, 1'b1, 1'b1, $urandom_range(0, 127), $urandom);
      else               cyc(1'b0, $urandom_range(0, 9) != 0);
    end

    check("queue_drained", 128'(exp_q.size()), 128'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
